// File: rtl/ele_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ele_pkg
//  Brief    : Shared state, run-mode and floor encodings for the elevator.
//  Revision : 1.0  initial release
// ============================================================================
package ele_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [3:0] FLOOR1 = 4'b0001;
    localparam logic [3:0] FLOOR2 = 4'b0010;
    localparam logic [3:0] FLOOR3 = 4'b0100;
    localparam logic [3:0] FLOOR4 = 4'b1000;

    function automatic logic [1:0] onehot2bin(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            FLOOR2:  idx = 2'd1;
            FLOOR3:  idx = 2'd2;
            FLOOR4:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ele_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ele_motion_ctrl_if
//  Brief    : Request-processor <-> motion controller bundle.
//             open_btn exists only when ELE_DOOR_REOPEN_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface ele_motion_ctrl_if;

`ifdef ELE_DOOR_REOPEN_EN
    logic       open_btn;
`endif
    logic [1:0] ud_mode;
    logic [3:0] all_req;
    logic [3:0] position;
    logic [1:0] floor_idx;
    logic       door_open;
    logic       moving;
    logic [1:0] dir;

    modport master (
`ifdef ELE_DOOR_REOPEN_EN
        output open_btn,
`endif
        output ud_mode, all_req,
        input  position, floor_idx, door_open, moving, dir
    );

    modport slave (
`ifdef ELE_DOOR_REOPEN_EN
        input  open_btn,
`endif
        input  ud_mode, all_req,
        output position, floor_idx, door_open, moving, dir
    );

endinterface
`default_nettype wire

// File: rtl/ele_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ele_tick_timer
//  Brief    : Clearable tick counter with terminal-count compare against the
//             travel or door limit.
//  Revision : 1.0  initial release
// ============================================================================
module ele_tick_timer #(
    parameter int CNT_W        = 8,
    parameter int TRAVEL_TICKS = 64,
    parameter int DOOR_TICKS   = 96
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_selDoor,
    output logic      o_tc
);

    localparam logic [CNT_W-1:0] c_TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] c_DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == (i_selDoor ? c_DOOR_LAST : c_TRAVEL_LAST));

endmodule
`default_nettype wire

// File: rtl/ele_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ele_motion_ctrl
//  Brief    : Car motion and door sequencer; all outputs registered.
//             Optional door reopen button under ELE_DOOR_REOPEN_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ele_motion_ctrl
    import ele_pkg::*;
#(
    parameter int TRAVEL_TICKS = 64,
    parameter int DOOR_TICKS   = 96,
    parameter int CNT_W        = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ele_motion_ctrl_if.slave   bus
);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_position;
    logic [3:0] w_nextPos;
    logic [1:0] r_floorIdx;
    logic       r_doorOpen;
    logic       r_moving;
    logic [1:0] r_dir;
    logic       w_tc;
    logic       w_reopen;
    logic       w_cntClr;
    logic       w_openBtn;

`ifdef ELE_DOOR_REOPEN_EN
    assign w_openBtn = bus.open_btn;
`else
    assign w_openBtn = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextPos   = r_position;
        w_reopen    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_openBtn || (|(bus.all_req & r_position))) begin
                    w_nextState = DOOR_OPEN;
                end else if (bus.ud_mode == UD_UP && r_position != FLOOR4) begin
                    w_nextState = MOVE_UP;
                end else if (bus.ud_mode == UD_DOWN && r_position != FLOOR1) begin
                    w_nextState = MOVE_DOWN;
                end
            end
            MOVE_UP: begin
                if (w_tc) begin
                    // Stop decision sees all_req before the arrived floor is cleared upstream
                    w_nextPos = {r_position[2:0], 1'b0};
                    if ((|(bus.all_req & w_nextPos)) || w_nextPos == FLOOR4 ||
                        bus.ud_mode != UD_UP) begin
                        w_nextState = DOOR_OPEN;
                    end
                end
            end
            MOVE_DOWN: begin
                if (w_tc) begin
                    w_nextPos = {1'b0, r_position[3:1]};
                    if ((|(bus.all_req & w_nextPos)) || w_nextPos == FLOOR1 ||
                        bus.ud_mode != UD_DOWN) begin
                        w_nextState = DOOR_OPEN;
                    end
                end
            end
            DOOR_OPEN: begin
                if (w_openBtn) begin
                    w_reopen = 1'b1;
                end else if (w_tc) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Counter sits at zero in IDLE and restarts on every entry or floor crossing
    assign w_cntClr = (r_state == IDLE) || (w_nextState != r_state) || w_reopen ||
                      (w_tc && (r_state == MOVE_UP || r_state == MOVE_DOWN));

    ele_tick_timer #(
        .CNT_W        (CNT_W),
        .TRAVEL_TICKS (TRAVEL_TICKS),
        .DOOR_TICKS   (DOOR_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cntClr),
        .i_selDoor (r_state == DOOR_OPEN),
        .o_tc      (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_position <= FLOOR1;
            r_floorIdx <= 2'd0;
            r_doorOpen <= 1'b0;
            r_moving   <= 1'b0;
            r_dir      <= UD_STOP;
        end else begin
            r_state    <= w_nextState;
            r_position <= w_nextPos;
            r_floorIdx <= onehot2bin(w_nextPos);
            r_doorOpen <= (w_nextState == DOOR_OPEN);
            r_moving   <= (w_nextState == MOVE_UP) || (w_nextState == MOVE_DOWN);
            r_dir      <= (w_nextState == MOVE_UP)   ? UD_UP   :
                          (w_nextState == MOVE_DOWN) ? UD_DOWN : UD_STOP;
        end
    end

    assign bus.position  = r_position;
    assign bus.floor_idx = r_floorIdx;
    assign bus.door_open = r_doorOpen;
    assign bus.moving    = r_moving;
    assign bus.dir       = r_dir;

endmodule
`default_nettype wire
